// File: rtl/mem_access_stage.sv
// MEM stage: issues aligned loads/stores on a req/ack bus and registers MEM/WB; ALU ops 1 cycle, memory ops 1 cycle after ack.
// Backpressure: stall holds upstream from issue until ack or timeout; misaligned ops and timeouts retire as bubbles with an error pulse.
module mem_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] result,
    input  logic        ALUM2Reg,
    input  logic        DataMemRW,
    input  logic [31:0] readData2,
    input  logic [4:0]  r2wr,
    input  logic        if_wr_reg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_r2wr,
    output logic        wb_if_wr_reg,
    output logic        misalign_err,
    output logic        timeout_err
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic            r_is_load;
    logic [4:0]      r_lat_r2wr;
    logic            r_lat_wr;

    logic w_mem_op;
    logic w_aligned;
    logic w_timeout_hit;

    assign w_mem_op      = ALUM2Reg | DataMemRW;
    assign w_aligned     = (result[1:0] == 2'b00);
    assign w_timeout_hit = (r_state == BUSY) && (r_count == CW'(TIMEOUT - 1));

    // Ack beats a coincident timeout, so both release the stall in the same cycle.
    assign stall = Rst_n & ((r_state == IDLE) ? (w_mem_op & w_aligned)
                                              : !(mem_ack | w_timeout_hit));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_is_load    <= 1'b0;
            r_lat_r2wr   <= '0;
            r_lat_wr     <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wb_data      <= '0;
            wb_r2wr      <= '0;
            wb_if_wr_reg <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_mem_op) begin
                        wb_data      <= result;
                        wb_r2wr      <= r2wr;
                        wb_if_wr_reg <= if_wr_reg;
                    end else if (w_aligned) begin
                        mem_req      <= 1'b1;
                        mem_we       <= DataMemRW;
                        mem_addr     <= result;
                        mem_wdata    <= readData2;
                        r_is_load    <= ~DataMemRW;
                        r_lat_r2wr   <= r2wr;
                        r_lat_wr     <= if_wr_reg;
                        r_count      <= '0;
                        wb_if_wr_reg <= 1'b0;
                        r_state      <= BUSY;
                    end else begin
                        wb_if_wr_reg <= 1'b0;
                        misalign_err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        r_state <= IDLE;
                        if (r_is_load) begin
                            wb_data      <= mem_rdata;
                            wb_r2wr      <= r_lat_r2wr;
                            wb_if_wr_reg <= r_lat_wr;
                        end else begin
                            wb_data      <= '0;
                            wb_if_wr_reg <= 1'b0;
                        end
                    end else if (w_timeout_hit) begin
                        mem_req      <= 1'b0;
                        wb_if_wr_reg <= 1'b0;
                        timeout_err  <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        wb_if_wr_reg <= 1'b0;
                        r_count      <= r_count + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
module tb_mem_access_stage;
    localparam int TO = 4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] result = '0;
    logic        ALUM2Reg = 1'b0;
    logic        DataMemRW = 1'b0;
    logic [31:0] readData2 = '0;
    logic [4:0]  r2wr = '0;
    logic        if_wr_reg = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_r2wr;
    logic        wb_if_wr_reg, misalign_err, timeout_err;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_t;

    wb_t sb[$];
    int  errors = 0;
    int  checks = 0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .result(result), .ALUM2Reg(ALUM2Reg),
        .DataMemRW(DataMemRW), .readData2(readData2), .r2wr(r2wr), .if_wr_reg(if_wr_reg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .wb_data(wb_data),
        .wb_r2wr(wb_r2wr), .wb_if_wr_reg(wb_if_wr_reg), .misalign_err(misalign_err),
        .timeout_err(timeout_err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic set_nop;
        result = '0; ALUM2Reg = 1'b0; DataMemRW = 1'b0; readData2 = '0;
        r2wr = '0; if_wr_reg = 1'b0; mem_ack = 1'b0;
    endtask

    // Drives one memory op from its issue negedge; returns at the negedge after the completing edge.
    task automatic run_mem(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd, input int ack_at, input logic [31:0] rdata,
                           output int n_stall, output int n_req, output logic [31:0] o_addr,
                           output logic [31:0] o_wdata, output logic o_we, output logic stable);
        logic done;
        n_stall = 0; n_req = 0; stable = 1'b1; o_addr = '0; o_wdata = '0; o_we = 1'b0;
        result = addr; readData2 = wd; r2wr = rd; if_wr_reg = 1'b1;
        ALUM2Reg = ~st; DataMemRW = st; mem_ack = 1'b0;
        #1;
        if (stall) n_stall++;
        tick;
        for (int j = 1; j <= TO + 4; j++) begin
            mem_ack   = (j == ack_at);
            mem_rdata = (j == ack_at) ? rdata : (32'h0BAD_0000 + 32'(j));
            #1;
            if (stall) n_stall++;
            if (mem_req) begin
                if (n_req == 0) begin
                    o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
                end else if (o_addr !== mem_addr || o_wdata !== mem_wdata || o_we !== mem_we) begin
                    stable = 1'b0;
                end
                n_req++;
            end
            done = !stall;
            tick;
            if (done) break;
        end
        set_nop();
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        set_nop();
        result = 32'h100; ALUM2Reg = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, wb_data, wb_r2wr, wb_if_wr_reg, misalign_err, timeout_err} !== '0) begin
            errors++; $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h wbd=%h wbr=%0d wbw=%b mis=%b to=%b want all 0",
                               mem_req, mem_we, mem_addr, mem_wdata, wb_data, wb_r2wr, wb_if_wr_reg, misalign_err, timeout_err);
        end
        set_nop();
        tick;
        Rst_n = 1'b1;
        tick;
    endtask

    task automatic test_alu;
        wb_t e;
        result = 32'h0000_1234; r2wr = 5'd5; if_wr_reg = 1'b1;
        sb.push_back('{data: 32'h0000_1234, rd: 5'd5});
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", stall); end
        tick;
        set_nop();
        checks++;
        if (wb_if_wr_reg !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL alu_wb_en: got %b want 1 (queue %0d)", wb_if_wr_reg, sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            if (wb_data !== e.data || wb_r2wr !== e.rd)
                begin errors++; $display("FAIL alu_wb: got %h/%0d want %h/%0d", wb_data, wb_r2wr, e.data, e.rd); end
        end
        tick;
    endtask

    task automatic test_load;
        int ns, nr; logic [31:0] a, w; logic we, stb; wb_t e;
        sb.push_back('{data: 32'hDEAD_BEEF, rd: 5'd9});
        run_mem(1'b0, 32'h100, 32'h0, 5'd9, 3, 32'hDEAD_BEEF, ns, nr, a, w, we, stb);
        checks++;
        if (ns !== 3 || nr !== 3) begin errors++; $display("FAIL load_cycles: stall=%0d req=%0d want 3/3", ns, nr); end
        checks++;
        if (a !== 32'h100 || we !== 1'b0 || !stb) begin errors++; $display("FAIL load_bus: addr=%h we=%b stable=%b want 100/0/1", a, we, stb); end
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop: got %b want 0", mem_req); end
        checks++;
        if (wb_if_wr_reg !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL load_wb_en: got %b want 1 (queue %0d)", wb_if_wr_reg, sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            if (wb_data !== e.data || wb_r2wr !== e.rd)
                begin errors++; $display("FAIL load_wb: got %h/%0d want %h/%0d", wb_data, wb_r2wr, e.data, e.rd); end
        end
        tick;
        checks++;
        if (wb_if_wr_reg !== 1'b0) begin errors++; $display("FAIL load_wb_once: got %b want 0", wb_if_wr_reg); end
    endtask

    task automatic test_store;
        int ns, nr; logic [31:0] a, w; logic we, stb;
        run_mem(1'b1, 32'h200, 32'hCAFE_F00D, 5'd7, 1, 32'h1111_1111, ns, nr, a, w, we, stb);
        checks++;
        if (ns !== 1 || nr !== 1) begin errors++; $display("FAIL store_cycles: stall=%0d req=%0d want 1/1", ns, nr); end
        checks++;
        if (a !== 32'h200 || w !== 32'hCAFE_F00D || we !== 1'b1)
            begin errors++; $display("FAIL store_bus: addr=%h wdata=%h we=%b want 200/cafef00d/1", a, w, we); end
        checks++;
        if (wb_if_wr_reg !== 1'b0 || sb.size() != 0)
            begin errors++; $display("FAIL store_no_wb: got %b want 0 (queue %0d)", wb_if_wr_reg, sb.size()); end
        tick;
    endtask

    task automatic test_misalign;
        result = 32'h102; ALUM2Reg = 1'b1; r2wr = 5'd4; if_wr_reg = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b want 0", stall); end
        tick;
        set_nop();
        checks++;
        if (misalign_err !== 1'b1 || mem_req !== 1'b0 || wb_if_wr_reg !== 1'b0)
            begin errors++; $display("FAIL mis_pulse: err=%b req=%b wbw=%b want 1/0/0", misalign_err, mem_req, wb_if_wr_reg); end
        tick;
        checks++;
        if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b want 0", misalign_err); end
    endtask

    task automatic test_timeout;
        int ns, nr; logic [31:0] a, w; logic we, stb; wb_t e;
        run_mem(1'b0, 32'h300, 32'h0, 5'd3, 0, 32'h0, ns, nr, a, w, we, stb);
        checks++;
        if (ns !== TO || nr !== TO) begin errors++; $display("FAIL to_cycles: stall=%0d req=%0d want %0d/%0d", ns, nr, TO, TO); end
        checks++;
        if (timeout_err !== 1'b1 || wb_if_wr_reg !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL to_pulse: err=%b wbw=%b req=%b want 1/0/0", timeout_err, wb_if_wr_reg, mem_req); end
        tick;
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b want 0", timeout_err); end
        sb.push_back('{data: 32'h0123_4567, rd: 5'd12});
        run_mem(1'b0, 32'h304, 32'h0, 5'd12, TO, 32'h0123_4567, ns, nr, a, w, we, stb);
        checks++;
        if (ns !== TO || nr !== TO) begin errors++; $display("FAIL to_ack_cycles: stall=%0d req=%0d want %0d/%0d", ns, nr, TO, TO); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_ack_no_err: got %b want 0", timeout_err); end
        checks++;
        if (wb_if_wr_reg !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL to_ack_wb_en: got %b want 1 (queue %0d)", wb_if_wr_reg, sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            if (wb_data !== e.data || wb_r2wr !== e.rd)
                begin errors++; $display("FAIL to_ack_wb: got %h/%0d want %h/%0d", wb_data, wb_r2wr, e.data, e.rd); end
        end
        tick;
    endtask

    task automatic test_reset_mid_access;
        wb_t e;
        result = 32'h400; ALUM2Reg = 1'b1; r2wr = 5'd6; if_wr_reg = 1'b1;
        tick;
        tick;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: req=%b want 1", mem_req); end
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, stall, mem_we, mem_addr, wb_data, wb_r2wr, wb_if_wr_reg, timeout_err} !== '0)
            begin errors++; $display("FAIL rst_mid_clear: req=%b stall=%b addr=%h wbd=%h wbw=%b want all 0", mem_req, stall, mem_addr, wb_data, wb_if_wr_reg); end
        set_nop();
        tick;
        Rst_n = 1'b1;
        result = 32'h55; r2wr = 5'd3; if_wr_reg = 1'b1;
        sb.push_back('{data: 32'h55, rd: 5'd3});
        tick;
        set_nop();
        checks++;
        if (wb_if_wr_reg !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL rst_alu_wb_en: got %b want 1 (queue %0d)", wb_if_wr_reg, sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            if (wb_data !== e.data || wb_r2wr !== e.rd)
                begin errors++; $display("FAIL rst_alu_wb: got %h/%0d want %h/%0d", wb_data, wb_r2wr, e.data, e.rd); end
        end
        tick;
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid_access();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
